bip_control: RTL and testbench
==============================

# bip_control

Sequencing control unit for the 16-bit accumulator processor. It fetches instructions from program memory and decodes the 5-bit opcode. It drives the accumulator/operand multiplexer selects, the accumulator write enable, the adder/subtractor operation and the data-memory strobes through a multi-cycle state machine. It sits between program memory and the multiplexer + adder/subtractor datapath.

## Interface
- NBITS_D, 16: instruction and data width.
- NBITS_PC, 11: program counter / operand width (= NBITS_D − 5).
- i_clock  in  1  single system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  begin execution from IDLE.
- i_instruction  in  NBITS_D  program memory read data, opcode [15:11], operand [10:0].
- o_pc  out  NBITS_PC  program memory address.
- o_operand  out  NBITS_PC  instruction register operand, feeds the data address and the sign-extension unit.
- o_SelA  out  2  accumulator source: 00 data memory, 01 extended immediate, 10 ALU result.
- o_SelB  out  1  ALU B operand: 0 data memory, 1 extended immediate.
- o_WrAcc  out  1  accumulator write strobe.
- o_Op  out  1  0 add, 1 subtract.
- o_WrRam  out  1  data memory write strobe (accumulator → mem[o_operand]).
- o_RdRam  out  1  data memory read strobe.
- o_halt  out  1  high in HALT.

## Operation
States and transitions:
- IDLE: go to FETCH on i_start.
- FETCH: o_pc is valid; go to DECODE.
- DECODE: i_instruction is valid and is latched into IR at the end of the cycle.
  - LD, ADD, SUB → READ.
  - HLT → HALT.
  - All others → EXEC.
- READ: o_RdRam=1; go to EXEC.
- EXEC: strobes asserted; PC ← PC+1; go to FETCH.
- HALT: terminal until reset.

Decoding (applies in EXEC; o_WrAcc=1 unless stated):
- 00001 STO: o_WrRam=1, o_WrAcc=0.
- 00010 LD: SelA=00.
- 00011 LDI: SelA=01.
- 00100 ADD: SelA=10, SelB=0, Op=0.
- 00101 ADDI: SelA=10, SelB=1, Op=0.
- 00110 SUB: SelA=10, SelB=0, Op=1.
- 00111 SUBI: SelA=10, SelB=1, Op=1.
- 00000 HLT.
- Any other opcode: NOP. The FSM goes DECODE→EXEC with no strobes, and the PC still increments.

Rules:
- Outside EXEC: o_WrAcc, o_WrRam = 0.
- Outside READ: o_RdRam = 0.
- Selects and Op are held at their decoded values from READ through EXEC, and are 0 otherwise.
- PC wraps 2047→0 modulo 2^NBITS_PC, with no flag.
- o_operand = IR[10:0] at all times after DECODE.

## Timing
- Reset (asynchronous, any state including mid-instruction):
  - state IDLE, PC=0, IR=0.
  - All outputs 0, o_halt=0.
  - No strobe may glitch high during or after reset.
- Program memory is synchronous: o_pc presented in FETCH yields i_instruction in DECODE.
- Data memory is synchronous: o_RdRam in READ yields data in EXEC.
- Latency per instruction:
  - STO/LDI/ADDI/SUBI/NOP: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ADD/SUB: 4 cycles.
  - HLT: 2 cycles to reach HALT.
- PC updates on the clock edge that ends EXEC; o_pc shows the new value in the following FETCH.
- i_start is ignored outside IDLE; holding it high in IDLE starts on the first edge.
- In HALT, o_halt=1, the PC is frozen at the HLT address, and all strobes are 0.

## Configuration
- CYCLE_COUNTER_EN defined:
  - Adds output o_cycles (32 bits), reset to 0.
  - Increments every cycle in FETCH/DECODE/READ/EXEC and freezes in HALT and IDLE.
  - Saturates at all-ones.
- CYCLE_COUNTER_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package bip_pkg holds:
  - opcode localparams (OP_HLT … OP_SUBI);
  - SelA encodings (SELA_MEM, SELA_IMM, SELA_ALU);
  - state encodings (ST_IDLE, ST_FETCH, ST_DECODE, ST_READ, ST_EXEC, ST_HALT).
- One natural sub-module, bip_decoder: purely combinational, IR opcode → {SelA, SelB, Op, WrAcc, WrRam, RdRam, needs_read, is_halt}.
- bip_control owns the FSM, PC, IR and strobe gating.

## Test plan
- Reset mid-EXEC of ADDI → all outputs 0 immediately; after i_start, o_pc=0 and FETCH resumes.
- Program LDI 5; ADDI 3; STO 7; HLT → strobe sequence:
  - WrAcc/SelA=01 at cycle 3;
  - WrAcc/SelA=10/SelB=1/Op=0 at cycle 6;
  - WrRam with o_operand=7 at cycle 9;
  - o_halt=1 with o_pc=3.
- LD 4; SUB 4 → o_RdRam asserted one cycle before each EXEC; each instruction takes 4 cycles; SUB has Op=1, SelB=0.
- Opcode 11111 → no strobes, and o_pc increments by 1 after 3 cycles.
- PC at 2047 executing LDI → next o_pc=0.
- CYCLE_COUNTER_EN with LDI 1; HLT → o_cycles=5 and stays 5 in HALT.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator processor control path.
// Holds the opcode map, the accumulator source encodings and the sequencer states.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/bip_if.sv
// Bundle between the sequencer, program memory and the accumulator datapath.
// o_cycles exists only when CYCLE_COUNTER_EN is defined.
interface bip_if #(
    parameter int NBITS_D  = 16,
    parameter int NBITS_PC = 11
);
    logic                i_start;
    logic [NBITS_D-1:0]  i_instruction;
    logic [NBITS_PC-1:0] o_pc;
    logic [NBITS_PC-1:0] o_operand;
    logic [1:0]          o_SelA;
    logic                o_SelB;
    logic                o_WrAcc;
    logic                o_Op;
    logic                o_WrRam;
    logic                o_RdRam;
    logic                o_halt;
`ifdef CYCLE_COUNTER_EN
    logic [31:0]         o_cycles;
`endif

    modport master (
        input  i_start, i_instruction,
        output o_pc, o_operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_halt
`ifdef CYCLE_COUNTER_EN
        , output o_cycles
`endif
    );

    modport slave (
        output i_start, i_instruction,
        input  o_pc, o_operand, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_halt
`ifdef CYCLE_COUNTER_EN
        , input o_cycles
`endif
    );
endinterface

// File: rtl/bip_decoder.sv
// Opcode to datapath-control lookup; purely combinational.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [1:0] selA,
    output logic       selB,
    output logic       op,
    output logic       wrAcc,
    output logic       wrRam,
    output logic       rdRam,
    output logic       needsRead,
    output logic       isHalt
);
    always_comb begin
        selA      = SELA_MEM;
        selB      = 1'b0;
        op        = 1'b0;
        wrAcc     = 1'b0;
        wrRam     = 1'b0;
        rdRam     = 1'b0;
        needsRead = 1'b0;
        isHalt    = 1'b0;
        case (opcode)
            OP_HLT:  isHalt = 1'b1;
            OP_STO:  wrRam = 1'b1;
            OP_LD:   begin selA = SELA_MEM; wrAcc = 1'b1; rdRam = 1'b1; needsRead = 1'b1; end
            OP_LDI:  begin selA = SELA_IMM; wrAcc = 1'b1; end
            OP_ADD:  begin selA = SELA_ALU; wrAcc = 1'b1; rdRam = 1'b1; needsRead = 1'b1; end
            OP_ADDI: begin selA = SELA_ALU; selB = 1'b1; wrAcc = 1'b1; end
            OP_SUB:  begin selA = SELA_ALU; op = 1'b1; wrAcc = 1'b1; rdRam = 1'b1; needsRead = 1'b1; end
            OP_SUBI: begin selA = SELA_ALU; selB = 1'b1; op = 1'b1; wrAcc = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/bip_control.sv
// Multi-cycle sequencer: fetch, decode, optional data read, execute, halt.
// Optional saturating busy-cycle counter enabled by CYCLE_COUNTER_EN.
module bip_control
    import bip_pkg::*;
#(
    parameter int NBITS_D  = 16,
    parameter int NBITS_PC = 11
) (
    input  logic  i_clock,
    input  logic  i_reset,
    bip_if.master bus
);
    state_t              state;
    logic [NBITS_PC-1:0] pc;
    logic [NBITS_D-1:0]  ir;
    logic [1:0]          selA;
    logic                selB, op, wrAcc, wrRam, rdRam, halt;

    logic [4:0] decOpcode;
    logic [1:0] decSelA;
    logic       decSelB, decOp, decWrAcc, decWrRam, decRdRam, decNeedsRead, decIsHalt;

    // In DECODE the fresh memory word is decoded so strobes can be registered on the same edge that latches IR.
    assign decOpcode = (state == ST_DECODE) ? bus.i_instruction[NBITS_D-1 -: 5]
                                            : ir[NBITS_D-1 -: 5];

    bip_decoder u_decoder (
        .opcode    (decOpcode),
        .selA      (decSelA),
        .selB      (decSelB),
        .op        (decOp),
        .wrAcc     (decWrAcc),
        .wrRam     (decWrRam),
        .rdRam     (decRdRam),
        .needsRead (decNeedsRead),
        .isHalt    (decIsHalt)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            selA  <= SELA_MEM;
            selB  <= 1'b0;
            op    <= 1'b0;
            wrAcc <= 1'b0;
            wrRam <= 1'b0;
            rdRam <= 1'b0;
            halt  <= 1'b0;
        end else begin
            wrAcc <= 1'b0;
            wrRam <= 1'b0;
            rdRam <= 1'b0;
            case (state)
                ST_IDLE:  if (bus.i_start) state <= ST_FETCH;
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    ir <= bus.i_instruction;
                    if (decIsHalt) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else begin
                        selA <= decSelA;
                        selB <= decSelB;
                        op   <= decOp;
                        if (decNeedsRead) begin
                            state <= ST_READ;
                            rdRam <= decRdRam;
                        end else begin
                            state <= ST_EXEC;
                            wrAcc <= decWrAcc;
                            wrRam <= decWrRam;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_EXEC;
                    wrAcc <= decWrAcc;
                    wrRam <= decWrRam;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    pc    <= pc + 1'b1;
                    selA  <= SELA_MEM;
                    selB  <= 1'b0;
                    op    <= 1'b0;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_pc      = pc;
    assign bus.o_operand = ir[NBITS_PC-1:0];
    assign bus.o_SelA    = selA;
    assign bus.o_SelB    = selB;
    assign bus.o_Op      = op;
    assign bus.o_WrAcc   = wrAcc;
    assign bus.o_WrRam   = wrRam;
    assign bus.o_RdRam   = rdRam;
    assign bus.o_halt    = halt;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycles;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cycles <= '0;
        end else if (state inside {ST_FETCH, ST_DECODE, ST_READ, ST_EXEC} && cycles != '1) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign bus.o_cycles = cycles;
`endif
endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: expected per-cycle traces come from an instruction-level model.
`timescale 1ns/1ps
module tb_bip_control;
    import bip_pkg::*;

    localparam int NBITS_D  = 16;
    localparam int NBITS_PC = 11;
    localparam int MEMSZ    = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bip_if #(.NBITS_D(NBITS_D), .NBITS_PC(NBITS_PC)) bus ();

    bip_control #(.NBITS_D(NBITS_D), .NBITS_PC(NBITS_PC)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [MEMSZ];
    always @(posedge clk) bus.i_instruction <= mem[bus.o_pc];

    int errors = 0;
    int checks = 0;

    logic [31:0] expQ [$];
    logic [31:0] cycQ [$];

    logic [31:0] obs;
    assign obs = {2'b00, bus.o_halt, bus.o_RdRam, bus.o_WrRam, bus.o_Op, bus.o_WrAcc,
                  bus.o_SelB, bus.o_SelA, bus.o_operand, bus.o_pc};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [10:0] pc, input logic [10:0] opnd,
                                       input logic [1:0] sa, input logic sb, input logic wa,
                                       input logic op, input logic wr, input logic rd,
                                       input logic h);
        return {2'b00, h, rd, wr, op, wa, sb, sa, opnd, pc};
    endfunction

    // Instruction-level model: each instruction expands into its cycle sequence.
    task automatic buildTrace(input int maxInstr);
        int          pc;
        int          cyc;
        logic [10:0] opnd;
        logic [15:0] ins;
        logic [1:0]  sa;
        logic        sb, op, wa, wr, rdNeed;
        pc = 0; cyc = 0; opnd = '0;
        expQ.delete();
        cycQ.delete();
        for (int n = 0; n < maxInstr; n++) begin
            ins = mem[pc];
            expQ.push_back(mk(11'(pc), opnd, 2'd0, 0, 0, 0, 0, 0, 0)); cycQ.push_back(cyc); cyc++;
            expQ.push_back(mk(11'(pc), opnd, 2'd0, 0, 0, 0, 0, 0, 0)); cycQ.push_back(cyc); cyc++;
            opnd = ins[10:0];
            if (ins[15:11] == 5'd0) begin
                for (int k = 0; k < 3; k++) begin
                    expQ.push_back(mk(11'(pc), opnd, 2'd0, 0, 0, 0, 0, 0, 1));
                    cycQ.push_back(cyc);
                end
                return;
            end
            sa = 2'd0; sb = 0; op = 0; wa = 0; wr = 0; rdNeed = 0;
            case (ins[15:11])
                5'd1: wr = 1;
                5'd2: begin sa = 2'd0; wa = 1; rdNeed = 1; end
                5'd3: begin sa = 2'd1; wa = 1; end
                5'd4: begin sa = 2'd2; wa = 1; rdNeed = 1; end
                5'd5: begin sa = 2'd2; sb = 1; wa = 1; end
                5'd6: begin sa = 2'd2; op = 1; wa = 1; rdNeed = 1; end
                5'd7: begin sa = 2'd2; sb = 1; op = 1; wa = 1; end
                default: ;
            endcase
            if (rdNeed) begin
                expQ.push_back(mk(11'(pc), opnd, sa, sb, 0, op, 0, 1, 0)); cycQ.push_back(cyc); cyc++;
            end
            expQ.push_back(mk(11'(pc), opnd, sa, sb, wa, op, wr, 0, 0)); cycQ.push_back(cyc); cyc++;
            pc = (pc + 1) % MEMSZ;
        end
    endtask

    task automatic doReset();
        bus.i_start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic checkTrace(input string tag, input int first, input int last, input bit hold);
        for (int i = first; i < last; i++) begin
            @(negedge clk);
            if (!hold) bus.i_start = 1'b0;
            check($sformatf("%s[%0d]", tag, i), obs, expQ[i]);
`ifdef CYCLE_COUNTER_EN
            check($sformatf("%sCyc[%0d]", tag, i), bus.o_cycles, cycQ[i]);
`endif
        end
    endtask

    task automatic runProgram(input string tag, input int maxInstr, input bit hold);
        doReset();
        #1 check({tag, "Rst"}, obs, 32'd0);
`ifdef CYCLE_COUNTER_EN
        check({tag, "RstCyc"}, bus.o_cycles, 32'd0);
`endif
        @(negedge clk);
        #1 check({tag, "Idle"}, obs, 32'd0);
        bus.i_start = 1'b1;
        buildTrace(maxInstr);
        checkTrace(tag, 0, expQ.size(), hold);
        bus.i_start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [4:0] opc;
        bus.i_start = 1'b0;
        for (int a = 0; a < MEMSZ; a++) mem[a] = '0;
        repeat (2) @(negedge clk);

        // Reset while ADDI is executing, then a clean restart from PC 0.
        mem[0] = {OP_ADDI, 11'd3};
        mem[1] = {OP_HLT, 11'd0};
        doReset();
        bus.i_start = 1'b1;
        buildTrace(4);
        checkTrace("midExec", 0, 3, 0);
        #1 rst = 1'b1;
        #1 check("midExecRst", obs, 32'd0);
`ifdef CYCLE_COUNTER_EN
        check("midExecRstCyc", bus.o_cycles, 32'd0);
`endif
        runProgram("restart", 4, 0);

        mem[0] = {OP_LDI, 11'd5};
        mem[1] = {OP_ADDI, 11'd3};
        mem[2] = {OP_STO, 11'd7};
        mem[3] = {OP_HLT, 11'd0};
        runProgram("ldiAddiSto", 10, 0);

        mem[0] = {OP_LD, 11'd4};
        mem[1] = {OP_SUB, 11'd4};
        mem[2] = {OP_HLT, 11'd0};
        runProgram("ldSub", 10, 1);

        mem[0] = {5'b11111, 11'd0};
        mem[1] = {OP_HLT, 11'd0};
        runProgram("nop", 10, 0);

        mem[0] = {OP_LDI, 11'd1};
        mem[1] = {OP_HLT, 11'd0};
        runProgram("counter", 10, 0);

        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(3, 12);
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(0, 3) == 0) opc = 5'($urandom_range(8, 31));
                else                           opc = 5'($urandom_range(1, 7));
                mem[a] = {opc, 11'($urandom)};
            end
            mem[len] = {OP_HLT, 11'($urandom)};
            runProgram($sformatf("rand%0d", t), len + 2, 1'($urandom_range(0, 1)));
        end

        // Walk the PC through 2047 and back to 0.
        for (int a = 0; a < MEMSZ - 1; a++) mem[a] = {5'b11111, 11'(a)};
        mem[MEMSZ-1] = {OP_LDI, 11'd9};
        runProgram("wrap", MEMSZ + 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
